// File: rtl/bus_port_fifo_bank_if.sv
// Handshake bundle between bus agents and one bank of per-driver FIFOs.
interface bus_port_fifo_bank_if #(
  parameter int unsigned bits  = 32,
  parameter int unsigned drvrs = 4,
  parameter int unsigned depth = 8
) ();
  localparam int unsigned cw = $clog2(depth) + 1;

  logic [drvrs-1:0]      push;
  logic [drvrs*bits-1:0] D_push;
  logic [drvrs-1:0]      pop;
  logic [drvrs*bits-1:0] D_pop;
  logic [drvrs-1:0]      pndng;
  logic [drvrs-1:0]      full;
  logic [drvrs-1:0]      afull;
  logic [drvrs*cw-1:0]   count;
  logic [drvrs-1:0]      ovf;
  logic [drvrs-1:0]      ovf_clr;

  modport master (
    output push, D_push, pop, ovf_clr,
    input  D_pop, pndng, full, afull, count, ovf
  );

  modport slave (
    input  push, D_push, pop, ovf_clr,
    output D_pop, pndng, full, afull, count, ovf
  );
endinterface

// File: rtl/bus_port_fifo_bank.sv
// Bank of independent show-ahead FIFOs, one per bus driver, with selectable
// full policy (drop new / overwrite oldest), occupancy and sticky overflow.
module bus_port_fifo_bank #(
  parameter int unsigned bits      = 32,
  parameter int unsigned drvrs     = 4,
  parameter int unsigned depth     = 8,
  parameter int unsigned mode      = 0,
  parameter int unsigned afull_lvl = 6
) (
  input logic clock,
  input logic reset,
  bus_port_fifo_bank_if.slave bus
);
  localparam int unsigned aw = $clog2(depth);
  localparam int unsigned cw = aw + 1;

  logic [bits-1:0]  mem    [drvrs][depth];
  logic [aw-1:0]    rd_ptr [drvrs];
  logic [aw-1:0]    wr_ptr [drvrs];
  logic [cw-1:0]    cnt    [drvrs];
  logic [drvrs-1:0] ovf_q;

  logic [drvrs-1:0] is_full;
  logic [drvrs-1:0] is_empty;
  logic [drvrs-1:0] do_push;
  logic [drvrs-1:0] adv_head;
  logic [drvrs-1:0] ovf_set;

  // Overwrite mode turns a full-without-pop push into write-at-tail plus an
  // implicit head advance, so count holds at depth.
  always_comb begin
    is_full  = '0;
    is_empty = '0;
    do_push  = '0;
    adv_head = '0;
    ovf_set  = '0;
    for (int unsigned i = 0; i < drvrs; i++) begin
      is_full[i]  = (cnt[i] == cw'(depth));
      is_empty[i] = (cnt[i] == '0);
      ovf_set[i]  = bus.push[i] & is_full[i] & ~bus.pop[i];
      do_push[i]  = bus.push[i] & (~is_full[i] | bus.pop[i] | (mode == 1));
      adv_head[i] = (bus.pop[i] & ~is_empty[i]) | (ovf_set[i] & (mode == 1));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < drvrs; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int unsigned i = 0; i < drvrs; i++) begin
        if (do_push[i])  wr_ptr[i] <= wr_ptr[i] + aw'(1);
        if (adv_head[i]) rd_ptr[i] <= rd_ptr[i] + aw'(1);
        cnt[i]   <= cnt[i] + cw'(do_push[i]) - cw'(adv_head[i]);
        ovf_q[i] <= ovf_set[i] | (ovf_q[i] & ~bus.ovf_clr[i]);
      end
    end
  end

  // Storage is not reset; only accepted pushes ever reach it.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < drvrs; i++) begin
      if (do_push[i]) mem[i][wr_ptr[i]] <= bus.D_push[i*bits +: bits];
    end
  end

  always_comb begin
    bus.D_pop = '0;
    bus.count = '0;
    for (int unsigned i = 0; i < drvrs; i++) begin
      bus.D_pop[i*bits +: bits] = is_empty[i] ? '0 : mem[i][rd_ptr[i]];
      bus.count[i*cw +: cw]     = cnt[i];
    end
  end

  always_comb begin
    bus.pndng = ~is_empty;
    bus.full  = is_full;
    bus.ovf   = ovf_q;
    bus.afull = '0;
    for (int unsigned i = 0; i < drvrs; i++) begin
      bus.afull[i] = (cnt[i] >= cw'(afull_lvl));
    end
  end
endmodule

// File: tb/tb_bus_port_fifo_bank.sv
// Scoreboard bench for bus_port_fifo_bank: a drop-mode and an overwrite-mode
// bank run side by side against per-channel queue models.
module tb_bus_port_fifo_bank;
  localparam int unsigned BITS = 32;
  localparam int unsigned DRV  = 4;
  localparam int unsigned DEP  = 8;
  localparam int unsigned AFL  = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bus_port_fifo_bank_if #(.bits(BITS), .drvrs(DRV), .depth(DEP)) if0 ();
  bus_port_fifo_bank_if #(.bits(BITS), .drvrs(DRV), .depth(DEP)) if1 ();

  bus_port_fifo_bank #(.bits(BITS), .drvrs(DRV), .depth(DEP), .mode(0), .afull_lvl(AFL))
    u0 (.clock(clock), .reset(reset), .bus(if0.slave));
  bus_port_fifo_bank #(.bits(BITS), .drvrs(DRV), .depth(DEP), .mode(1), .afull_lvl(AFL))
    u1 (.clock(clock), .reset(reset), .bus(if1.slave));

  int total = 0;
  int bad   = 0;

  logic [31:0] sbq [8][$];
  logic [3:0]  ovf_m [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of the model for one bank: compare state, then apply this cycle's inputs.
  task automatic scb(input int d, input logic [3:0] p, input logic [3:0] q,
                     input logic [3:0] clr, input logic [127:0] dp,
                     input logic [127:0] dq, input logic [3:0] pn,
                     input logic [3:0] fu, input logic [3:0] af,
                     input logic [15:0] cn, input logic [3:0] ov);
    logic [3:0] set;
    set = '0;
    chk($sformatf("d%0d ovf", d), 32'(ov), 32'(ovf_m[d]));
    for (int c = 0; c < 4; c++) begin
      int idx;
      int n;
      idx = d * 4 + c;
      n   = sbq[idx].size();
      chk($sformatf("d%0d ch%0d pndng", d, c), 32'(pn[c]), 32'(n > 0));
      chk($sformatf("d%0d ch%0d count", d, c), 32'(cn[c*4 +: 4]), 32'(n));
      chk($sformatf("d%0d ch%0d full", d, c), 32'(fu[c]), 32'(n == 8));
      chk($sformatf("d%0d ch%0d afull", d, c), 32'(af[c]), 32'(n >= 6));
      chk($sformatf("d%0d ch%0d D_pop", d, c), dq[c*32 +: 32], (n > 0) ? sbq[idx][0] : 32'd0);
      if (q[c] && n > 0) void'(sbq[idx].pop_front());
      if (p[c]) begin
        if (n == 8 && !q[c]) begin
          set[c] = 1'b1;
          if (d == 1) begin
            void'(sbq[idx].pop_front());
            sbq[idx].push_back(dp[c*32 +: 32]);
          end
        end else begin
          sbq[idx].push_back(dp[c*32 +: 32]);
        end
      end
    end
    ovf_m[d] = set | (ovf_m[d] & ~clr);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) sbq[i].delete();
      ovf_m[0] = '0;
      ovf_m[1] = '0;
    end else begin
      scb(0, if0.push, if0.pop, if0.ovf_clr, if0.D_push, if0.D_pop, if0.pndng,
          if0.full, if0.afull, if0.count, if0.ovf);
      scb(1, if1.push, if1.pop, if1.ovf_clr, if1.D_push, if1.D_pop, if1.pndng,
          if1.full, if1.afull, if1.count, if1.ovf);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    if0.push = '0; if0.pop = '0; if0.ovf_clr = '0;
    if1.push = '0; if1.pop = '0; if1.ovf_clr = '0;
    if0.D_push = {$urandom, $urandom, $urandom, $urandom};
    if1.D_push = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic op(input int dut, input int c, input logic p, input logic [31:0] dat,
                    input logic q);
    if (dut == 0) begin
      if0.push[c] = p; if0.D_push[c*32 +: 32] = dat; if0.pop[c] = q;
    end else begin
      if1.push[c] = p; if1.D_push[c*32 +: 32] = dat; if1.pop[c] = q;
    end
    cyc();
    idle();
  endtask

  logic [3:0] pa, qa;

  initial begin
    idle();
    cyc();
    cyc();
    reset = 1'b0;

    // Reset asserted mid-cycle with data queued, then popping an empty bank.
    op(0, 0, 1'b1, 32'hDEAD_0001, 1'b0);
    op(1, 1, 1'b1, 32'hDEAD_0002, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("rst pndng0", 32'(if0.pndng), 32'd0);
    chk("rst count0", 32'(if0.count), 32'd0);
    chk("rst dpop0",  if0.D_pop[31:0], 32'd0);
    chk("rst pndng1", 32'(if1.pndng), 32'd0);
    chk("rst count1", 32'(if1.count), 32'd0);
    chk("rst ovf",    32'({if0.ovf, if1.ovf}), 32'd0);
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if0.pop[0] = 1'b1;
      if1.pop[0] = 1'b1;
      cyc();
      chk("empty pop pndng", 32'({if0.pndng, if1.pndng}), 32'd0);
      chk("empty pop count", 32'(if0.count), 32'd0);
    end
    idle();

    // Fill and drain ch2, drop mode.
    for (int k = 1; k <= 8; k++) begin
      op(0, 2, 1'b1, 32'h10 + 32'(k), 1'b0);
      chk("fill count", 32'(if0.count[8 +: 4]), 32'(k));
      chk("fill afull", 32'(if0.afull[2]), 32'(k >= 6));
      chk("fill full",  32'(if0.full[2]), 32'(k == 8));
    end
    for (int k = 1; k <= 8; k++) begin
      chk("drain data", if0.D_pop[64 +: 32], 32'h10 + 32'(k));
      op(0, 2, 1'b0, 32'd0, 1'b1);
    end
    chk("drain pndng", 32'(if0.pndng[2]), 32'd0);
    chk("drain dpop",  if0.D_pop[64 +: 32], 32'd0);

    // Overflow drop on ch1, set-wins against clear, then clear.
    for (int k = 1; k <= 8; k++) op(0, 1, 1'b1, 32'h20 + 32'(k), 1'b0);
    op(0, 1, 1'b1, 32'hAA, 1'b0);
    chk("drop ovf",   32'(if0.ovf[1]), 32'd1);
    chk("drop count", 32'(if0.count[4 +: 4]), 32'd8);
    if0.ovf_clr[1] = 1'b1;
    op(0, 1, 1'b1, 32'hAB, 1'b0);
    chk("ovf set wins", 32'(if0.ovf[1]), 32'd1);
    if0.ovf_clr[1] = 1'b1;
    cyc();
    idle();
    chk("ovf clr", 32'(if0.ovf[1]), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      chk("drop drain", if0.D_pop[32 +: 32], 32'h20 + 32'(k));
      op(0, 1, 1'b0, 32'd0, 1'b1);
    end
    chk("drop empty", 32'(if0.pndng[1]), 32'd0);

    // Overwrite-oldest on ch0 of the mode-1 bank.
    for (int k = 1; k <= 8; k++) op(1, 0, 1'b1, 32'(k), 1'b0);
    op(1, 0, 1'b1, 32'd9, 1'b0);
    op(1, 0, 1'b1, 32'd10, 1'b0);
    chk("ovw ovf",   32'(if1.ovf[0]), 32'd1);
    chk("ovw count", 32'(if1.count[3:0]), 32'd8);
    for (int k = 3; k <= 10; k++) begin
      chk("ovw drain", if1.D_pop[31:0], 32'(k));
      op(1, 0, 1'b0, 32'd0, 1'b1);
    end
    chk("ovw empty", 32'(if1.pndng[0]), 32'd0);

    // Simultaneous push/pop on ch3: full, then empty.
    for (int k = 1; k <= 8; k++) op(0, 3, 1'b1, 32'h30 + 32'(k), 1'b0);
    op(0, 3, 1'b1, 32'h55, 1'b1);
    chk("sim full count", 32'(if0.count[12 +: 4]), 32'd8);
    chk("sim full ovf",   32'(if0.ovf[3]), 32'd0);
    chk("sim full head",  if0.D_pop[96 +: 32], 32'h32);
    for (int k = 2; k <= 9; k++) begin
      chk("sim drain", if0.D_pop[96 +: 32], (k == 9) ? 32'h55 : 32'h30 + 32'(k));
      op(0, 3, 1'b0, 32'd0, 1'b1);
    end
    op(0, 3, 1'b1, 32'h66, 1'b1);
    chk("sim empty count", 32'(if0.count[12 +: 4]), 32'd1);
    chk("sim empty head",  if0.D_pop[96 +: 32], 32'h66);
    op(0, 3, 1'b0, 32'd0, 1'b1);

    // Mixed traffic on every channel of both banks, alternating fill/drain bias.
    for (int i = 0; i < 1000; i++) begin
      if (((i / 100) % 2) == 0) begin
        pa = 4'($urandom | $urandom); qa = 4'($urandom & $urandom);
      end else begin
        pa = 4'($urandom & $urandom); qa = 4'($urandom | $urandom);
      end
      if0.push = pa; if0.pop = qa;
      if0.D_push = {$urandom, $urandom, $urandom, $urandom};
      if0.ovf_clr = 4'($urandom & $urandom & $urandom);
      if1.push = 4'($urandom | $urandom); if1.pop = 4'($urandom);
      if1.D_push = {$urandom, $urandom, $urandom, $urandom};
      if1.ovf_clr = 4'($urandom & $urandom & $urandom);
      cyc();
    end
    idle();
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
